// File: rtl/alu_pkg.sv
// Shared opcode map and control-FSM encoding for the sequential ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD     = 5'b00011;
  localparam logic [4:0] OP_SUB     = 5'b00100;
  localparam logic [4:0] OP_SHR     = 5'b00101;
  localparam logic [4:0] OP_SHL     = 5'b00110;
  localparam logic [4:0] OP_ROR     = 5'b00111;
  localparam logic [4:0] OP_ROL     = 5'b01000;
  localparam logic [4:0] OP_AND     = 5'b01001;
  localparam logic [4:0] OP_OR      = 5'b01010;
  localparam logic [4:0] OP_AND_ALT = 5'b01100;
  localparam logic [4:0] OP_OR_ALT  = 5'b01101;
  localparam logic [4:0] OP_MUL     = 5'b01110;
  localparam logic [4:0] OP_DIV     = 5'b01111;
  localparam logic [4:0] OP_NEG     = 5'b10000;
  localparam logic [4:0] OP_NOT     = 5'b10001;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  function automatic logic is_long(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative signed multiply / restoring divide on operand magnitudes; one
// iteration per step, sign correction applied combinationally on the results.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             is_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             res_dz
);

  localparam int CW = $clog2(WIDTH);

  logic             div_q, div_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d, zero_q, zero_d;
  logic [WIDTH-1:0] a_q, a_d, mag_q, mag_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH+1:0] diff;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  // MUL: {hi,lo} holds partial product with multiplier in lo.
  // DIV: hi is the running remainder, lo shifts dividend out / quotient in.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, mag_q};
    div_d   = div_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    zero_d  = zero_q;
    a_d     = a_q;
    mag_d   = mag_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    if (load) begin
      div_d   = is_div;
      neg_a_d = a[WIDTH-1];
      neg_b_d = b[WIDTH-1];
      zero_d  = (b == '0);
      a_d     = a;
      mag_d   = is_div ? abs_val(b) : abs_val(a);
      hi_d    = '0;
      lo_d    = is_div ? abs_val(a) : abs_val(b);
      cnt_d   = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (div_q) begin
        hi_d = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], ~diff[WIDTH+1]};
      end else begin
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    last   = (cnt_q == CW'(WIDTH - 1));
    prod   = {hi_q, lo_q};
    res_dz = 1'b0;
    if (div_q) begin
      if (zero_q) begin
        res_hi = a_q;
        res_lo = '1;
        res_dz = 1'b1;
      end else begin
        res_hi = neg_a_q ? (~hi_q + 1'b1) : hi_q;
        res_lo = (neg_a_q ^ neg_b_q) ? (~lo_q + 1'b1) : lo_q;
      end
    end else begin
      if (neg_a_q ^ neg_b_q) prod = ~prod + 1'b1;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      zero_q  <= 1'b0;
      a_q     <= '0;
      mag_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      div_q   <= div_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      zero_q  <= zero_d;
      a_q     <= a_d;
      mag_q   <= mag_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle logic/shift/add ops in IDLE, MUL/DIV handed to
// the iterative datapath behind a start/busy/done handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zhi,
  output logic [WIDTH-1:0] zlo,
  output logic             dz
);

  localparam int SW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             accept, long_op, load, step, fix, last, md_dz;
  logic             dz_q, dz_d, done_q, done_d;
  logic [WIDTH-1:0] zhi_q, zhi_d, zlo_q, zlo_d, sc_res, md_hi, md_lo;
  logic [SW-1:0]    sh;

  assign long_op = is_long(opcode);
  assign accept  = (state_q == IDLE) && start;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && long_op) state_d = RUN;
      RUN:     if (last) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    load = accept && long_op;
    step = (state_q == RUN);
    fix  = (state_q == FIX);
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .clr    (clr),
    .load   (load),
    .is_div (opcode == OP_DIV),
    .step   (step),
    .a      (a),
    .b      (b),
    .last   (last),
    .res_hi (md_hi),
    .res_lo (md_lo),
    .res_dz (md_dz)
  );

  // Shifting by WIDTH yields zero, so a zero rotate amount returns a intact.
  always_comb begin
    sh     = b[SW-1:0];
    sc_res = '0;
    case (opcode)
      OP_ADD:             sc_res = a + b;
      OP_SUB:             sc_res = a - b;
      OP_SHR:             sc_res = a >> sh;
      OP_SHL:             sc_res = a << sh;
      OP_ROR:             sc_res = (a >> sh) | (a << (WIDTH - int'(sh)));
      OP_ROL:             sc_res = (a << sh) | (a >> (WIDTH - int'(sh)));
      OP_AND, OP_AND_ALT: sc_res = a & b;
      OP_OR, OP_OR_ALT:   sc_res = a | b;
      OP_NEG:             sc_res = '0 - a;
      OP_NOT:             sc_res = ~a;
      default:            sc_res = '0;
    endcase
  end

  always_comb begin
    zhi_d  = zhi_q;
    zlo_d  = zlo_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    if (accept && !long_op) begin
      zhi_d  = '0;
      zlo_d  = sc_res;
      dz_d   = 1'b0;
      done_d = 1'b1;
    end else if (fix) begin
      zhi_d  = md_hi;
      zlo_d  = md_lo;
      dz_d   = md_dz;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      zhi_q  <= '0;
      zlo_q  <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      zhi_q  <= zhi_d;
      zlo_q  <= zlo_d;
      dz_q   <= dz_d;
      done_q <= done_d;
    end
  end

  assign zhi  = zhi_q;
  assign zlo  = zlo_q;
  assign dz   = dz_q;
  assign done = done_q;

endmodule
